// File: rtl/mm_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
package mm_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned RW_DEF = 18;

    localparam logic [1:0] IDX_C00 = 2'd0;
    localparam logic [1:0] IDX_C01 = 2'd1;
    localparam logic [1:0] IDX_C10 = 2'd2;
    localparam logic [1:0] IDX_C11 = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone,
        StErr
    } seq_state_t;

endpackage

// File: rtl/mm_wdog.sv
// Watchdog counter for the ALU wait phase; expired when the count reaches TIMEOUT-1.
module mm_wdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    assign expired = (cnt_q == 8'(TIMEOUT - 1));

    // Hold at the limit so the count never wraps while the sequencer sits in ERR.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matmult_seq.sv
// Sequences four dot-product ALU operations to compute C = A x B for 2x2 matrices
// and writes each result element to the result memory port.
module matmult_seq
    import mm_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RW      = RW_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic            abort,
    input  logic [4*DW-1:0] a_flat,
    input  logic [4*DW-1:0] b_flat,
    output logic            alu_start,
    output logic [DW-1:0]   alu_row0,
    output logic [DW-1:0]   alu_row1,
    output logic [DW-1:0]   alu_col0,
    output logic [DW-1:0]   alu_col1,
    input  logic [RW-1:0]   alu_out,
    input  logic            alu_complete,
    output logic            res_wr,
    output logic [1:0]      res_addr,
    output logic [RW-1:0]   res_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    seq_state_t        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [4*DW-1:0]   a_q, b_q;
    logic [RW-1:0]     res_q;
    logic              latch, capture;
    logic              wdog_expired;

    mm_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == StIssue),
        .en      ((state_q == StWait) && !alu_complete),
        .expired (wdog_expired)
    );

    // Row operands follow idx[1], column operands follow idx[0].
    logic [DW-1:0] row0_sel, row1_sel, col0_sel, col1_sel;
    assign row0_sel = idx_q[1] ? a_q[2*DW-1 -: DW] : a_q[4*DW-1 -: DW];
    assign row1_sel = idx_q[1] ? a_q[DW-1:0]       : a_q[3*DW-1 -: DW];
    assign col0_sel = idx_q[0] ? b_q[3*DW-1 -: DW] : b_q[4*DW-1 -: DW];
    assign col1_sel = idx_q[0] ? b_q[DW-1:0]       : b_q[2*DW-1 -: DW];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        latch   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    latch   = 1'b1;
                    idx_d   = IDX_C00;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (alu_complete) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end else if (wdog_expired) begin
                    state_d = StErr;
                end
            end
            StWrite: begin
                if (idx_q == IDX_C11) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StIssue;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
        // abort overrides every other event, including a same-cycle completion.
        if (abort) begin
            state_d = StIdle;
            idx_d   = IDX_C00;
            latch   = 1'b0;
            capture = 1'b0;
        end
    end

    always_comb begin
        alu_start = (state_q == StIssue);
        res_wr    = (state_q == StWrite);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = (state_q == StErr);
        alu_row0  = '0;
        alu_row1  = '0;
        alu_col0  = '0;
        alu_col1  = '0;
        res_addr  = '0;
        res_data  = '0;
        if ((state_q == StIssue) || (state_q == StWait)) begin
            alu_row0 = row0_sel;
            alu_row1 = row1_sel;
            alu_col0 = col0_sel;
            alu_col1 = col1_sel;
        end
        if (state_q == StWrite) begin
            res_addr = idx_q;
            res_data = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= IDX_C00;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) begin
                a_q <= a_flat;
                b_q <= b_flat;
            end
            if (capture) begin
                res_q <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_matmult_seq.sv
// Randomized self-checking bench for matmult_seq with a mock dot-product ALU.
module tb_matmult_seq;

    localparam int unsigned DW      = 8;
    localparam int unsigned RW      = 18;
    localparam int unsigned TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            go = 1'b0;
    logic            abort = 1'b0;
    logic [4*DW-1:0] a_flat = '0;
    logic [4*DW-1:0] b_flat = '0;
    logic            alu_start;
    logic [DW-1:0]   alu_row0, alu_row1, alu_col0, alu_col1;
    logic [RW-1:0]   alu_out;
    logic            alu_complete;
    logic            res_wr;
    logic [1:0]      res_addr;
    logic [RW-1:0]   res_data;
    logic            busy, done, err;

    matmult_seq #(
        .DW      (DW),
        .RW      (RW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .abort        (abort),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .alu_start    (alu_start),
        .alu_row0     (alu_row0),
        .alu_row1     (alu_row1),
        .alu_col0     (alu_col0),
        .alu_col1     (alu_col1),
        .alu_out      (alu_out),
        .alu_complete (alu_complete),
        .res_wr       (res_wr),
        .res_addr     (res_addr),
        .res_data     (res_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Mock ALU: completes `lat` cycles into WAIT (lat=0 means never).
    int          lat = 1;
    int          alu_cnt;
    logic        alu_pend;
    logic [RW-1:0] alu_val;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_pend     <= 1'b0;
            alu_complete <= 1'b0;
            alu_out      <= '0;
            alu_cnt      <= 0;
            alu_val      <= '0;
        end else begin
            alu_complete <= 1'b0;
            if (alu_start) begin
                alu_val <= RW'(int'(alu_row0) * int'(alu_col0) + int'(alu_row1) * int'(alu_col1));
                alu_cnt  <= 1;
                alu_pend <= (lat != 1);
                if (lat == 1) begin
                    alu_complete <= 1'b1;
                    alu_out <= RW'(int'(alu_row0) * int'(alu_col0)
                                   + int'(alu_row1) * int'(alu_col1));
                end
            end else if (alu_pend) begin
                if (lat != 0 && alu_cnt + 1 == lat) begin
                    alu_complete <= 1'b1;
                    alu_out      <= alu_val;
                    alu_pend     <= 1'b0;
                end
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    // Mid-cycle monitor of result writes and pulses.
    int unsigned wq_addr[$];
    int unsigned wq_data[$];
    int          n_start, n_done;
    logic        err_seen;

    always @(negedge clk) begin
        if (res_wr) begin
            wq_addr.push_back(int'(res_addr));
            wq_data.push_back(int'(res_data));
        end
        if (alu_start) n_start++;
        if (done) n_done++;
        if (err) err_seen = 1'b1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] ma[2][2];
    logic [7:0] mb[2][2];

    function automatic int unsigned cval(input int i, input int j);
        return int'(ma[i][0]) * int'(mb[0][j]) + int'(ma[i][1]) * int'(mb[1][j]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        wq_addr.delete();
        wq_data.delete();
        n_start  = 0;
        n_done   = 0;
        err_seen = 1'b0;
    endtask

    task automatic load_flats();
        a_flat = {ma[0][0], ma[0][1], ma[1][0], ma[1][1]};
        b_flat = {mb[0][0], mb[0][1], mb[1][0], mb[1][1]};
    endtask

    task automatic rand_mats();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = 8'($urandom);
                mb[i][j] = 8'($urandom);
            end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            step();
            k++;
        end
        check_eq("job_done", n_done, 1);
        step();
    endtask

    task automatic check_writes(input string tag, input int n_exp);
        check_eq({tag, "_nwr"}, wq_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < wq_addr.size(); i++) begin
            check_eq({tag, "_addr"}, wq_addr[i], i);
            check_eq({tag, "_data"}, wq_data[i], cval(i / 2, i % 2));
        end
    endtask

    initial begin
        int         g;
        int         n;
        logic [13:0] st_m, wr_m, dn_m, by_m;

        // Reset state
        #12;
        check_eq("rst_ctrl", {busy, done, err, res_wr, alu_start}, 0);
        check_eq("rst_addr", res_addr, 0);
        check_eq("rst_data", res_data, 0);
        check_eq("rst_ops", {alu_row0, alu_row1, alu_col0, alu_col1}, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Latency and known result
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        lat = 1;
        clr_mon();
        load_flats();
        pulse_go();
        for (int k = 0; k < 14; k++) begin
            st_m[k] = alu_start;
            wr_m[k] = res_wr;
            dn_m[k] = done;
            by_m[k] = busy;
            step();
        end
        check_eq("lat_start", st_m, 14'h0249);
        check_eq("lat_wr", wr_m, 14'h0924);
        check_eq("lat_done", dn_m, 14'h1000);
        check_eq("lat_busy", by_m, 14'h1fff);
        check_writes("basic", 4);
        check_eq("basic_ndone", n_done, 1);

        // All 255, slow ALU
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = 8'hff;
                mb[i][j] = 8'hff;
            end
        lat = 5;
        clr_mon();
        load_flats();
        pulse_go();
        wait_done(200);
        check_writes("max", 4);
        check_eq("max_val", wq_data.size() > 0 ? wq_data[0] : 0, 130050);
        check_eq("max_nstart", n_start, 4);
        check_eq("max_noerr", err_seen, 0);

        // Random matrices and latencies
        for (int t = 0; t < 6; t++) begin
            rand_mats();
            lat = int'($urandom_range(1, 6));
            clr_mon();
            load_flats();
            pulse_go();
            wait_done(200);
            check_writes("rand", 4);
        end

        // Watchdog timeout
        lat = 0;
        clr_mon();
        pulse_go();
        check_eq("to_start", alu_start, 1);
        g = 0;
        step();
        while (!err && g < 300) begin
            g++;
            step();
        end
        check_eq("to_gap", g, TIMEOUT);
        check_eq("to_busy", busy, 1);
        pulse_go();
        check_eq("to_go_ign", err, 1);
        check_eq("to_nwr", wq_addr.size(), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("to_abort", {err, busy}, 0);

        // Abort in WAIT of idx2 together with alu_complete
        rand_mats();
        lat = 1;
        clr_mon();
        load_flats();
        pulse_go();
        n = 0;
        g = 0;
        while (n < 3 && g < 100) begin
            if (alu_start) n++;
            if (n < 3) step();
            g++;
        end
        step();
        check_eq("ab_cmpl", alu_complete, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check_writes("ab", 2);
        check_eq("ab_ndone", n_done, 0);
        check_eq("ab_busy", busy, 0);
        rand_mats();
        clr_mon();
        load_flats();
        pulse_go();
        wait_done(200);
        check_writes("ab_rst", 4);

        // go re-pulsed mid-run with zeroed operands
        rand_mats();
        lat = 3;
        clr_mon();
        load_flats();
        pulse_go();
        step();
        step();
        a_flat = '0;
        b_flat = '0;
        pulse_go();
        for (int k = 0; k < 8; k++) step();
        pulse_go();
        wait_done(200);
        check_writes("rego", 4);

        // Asynchronous reset during WRITE of idx1
        rand_mats();
        lat = 1;
        clr_mon();
        load_flats();
        pulse_go();
        g = 0;
        while (!(res_wr && res_addr == 2'd1) && g < 100) begin
            step();
            g++;
        end
        check_eq("ar_found", res_wr, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_ctrl", {busy, done, err, res_wr, alu_start}, 0);
        check_eq("ar_addr", res_addr, 0);
        check_eq("ar_data", res_data, 0);
        check_eq("ar_ops", {alu_row0, alu_row1, alu_col0, alu_col1}, 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (alu_start || busy) n++;
        end
        check_eq("ar_idle", n, 0);
        check_eq("ar_nwr", wq_addr.size(), 1);
        rand_mats();
        clr_mon();
        load_flats();
        pulse_go();
        wait_done(200);
        check_writes("ar_after", 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matmult_seq.md
Name: matmult_seq

Overview:
Sequencer that computes C = A x B for 2x2 matrices of 8-bit unsigned operands. It drives the shared dot-product ALU (row0*col0 + row1*col1, start/complete handshake) once per result element, in order c00, c01, c10, c11. Each 18-bit result is written into the result memory port. It sits between the command FSM, which supplies operands and pulses go, and the ALU/memory pair. A watchdog flags an ALU that never completes.

Parameters:
DW, 8, operand element width
RW, 18, result width (must be at least 2*DW+1)
TIMEOUT, 64, maximum WAIT cycles before err; legal range 2..255

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
go  input  1  start request; sampled only in IDLE
abort  input  1  synchronous cancel, accepted in any state
a_flat  input  4*DW  {a00,a01,a10,a11}, with a00 in the MSBs
b_flat  input  4*DW  {b00,b01,b10,b11}, with b00 in the MSBs
alu_start  output  1  one-cycle ALU launch
alu_row0, alu_row1, alu_col0, alu_col1  output  DW each  ALU operands
alu_out  input  RW  ALU result
alu_complete  input  1  ALU result valid
res_wr  output  1  result write strobe
res_addr  output  2  element index (0=c00, 1=c01, 2=c10, 3=c11)
res_data  output  RW  result word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the 4th write
err  output  1  high while in ERR

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, idx=0, wdog=0.
  - All outputs 0, including operand buses, res_addr and res_data.
- States: IDLE, ISSUE, WAIT, WRITE, DONE, ERR.
- IDLE:
  - go=1 latches a_flat and b_flat into internal registers, sets idx=0, and moves to ISSUE.
  - Operand inputs are ignored after this point.
- ISSUE:
  - alu_start=1 for exactly this cycle. Operand buses show element idx. Next state is WAIT, with wdog=0.
- Operand mapping (operand buses hold their value through ISSUE and WAIT):
  - idx0: a00, a01, b00, b10
  - idx1: a00, a01, b01, b11
  - idx2: a10, a11, b00, b10
  - idx3: a10, a11, b01, b11
- WAIT:
  - alu_complete=1 captures alu_out into the result register and moves to WRITE.
  - Otherwise wdog increments. When wdog reaches TIMEOUT-1 and alu_complete=0, the next state is ERR.
  - alu_complete is ignored in every state except WAIT.
- WRITE:
  - res_wr=1 for one cycle, with res_addr=idx and res_data=captured result.
  - If idx=3, next state is DONE. Otherwise idx increments and the next state is ISSUE.
- DONE: done=1 for one cycle, then IDLE.
- ERR:
  - err=1 and busy=1, held until abort. go is ignored.
  - No res_wr or alu_start is issued while in ERR.
- abort:
  - Takes priority over every other event, including a simultaneous alu_complete or timeout.
  - Next state is IDLE. No done pulse and no further writes.
  - Writes already performed are not undone.
- go while busy: ignored, with no effect on the latched operands.
- Latency with an ALU that asserts complete in the first WAIT cycle (go sampled at edge E0):
  - alu_start in cycles after E0, E3, E6 and E9.
  - res_wr in cycles after E2, E5, E8 and E11.
  - done in the cycle after E12; IDLE again after E13.
- Arithmetic: no truncation is possible. The worst case is 2*255*255 = 130050 < 2^18. The result is passed through unmodified.
- idx does not wrap: it is reset to 0 only on go, abort or rst.

Decomposition:
- Shared package mm_pkg:
  - state enum seq_state_t.
  - Element index localparams IDX_C00..IDX_C11.
  - DW and RW defaults.
- One sub-module, mm_wdog:
  - Inputs: clr, en.
  - Output: expired, asserted when count = TIMEOUT-1.
  - Parameterised by TIMEOUT.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], ALU mock latency 1 -> writes (0,19), (1,22), (2,43), (3,50) in that order, then a single done pulse; busy low after E13.
- All elements 255, ALU mock latency 5 -> four writes of 130050 each; exactly four alu_start pulses; err never asserted.
- TIMEOUT=64, mock ALU never completes -> err rises exactly 64 cycles after the first ISSUE; no res_wr; abort returns to IDLE with err=0 and busy=0.
- abort asserted in WAIT for idx2 in the same cycle as alu_complete -> exactly two writes (addr 0 and 1), no third write, no done pulse; a following go restarts at idx0.
- go re-pulsed mid-run with A and B changed to zero -> ignored; results match the originally latched operands.
- rst driven low during WRITE of idx1 -> all outputs 0 immediately (asynchronous); after release, the block sits in IDLE until the next go.
